// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole slot logic:
// mode encodings and LFSR constants.
package whack_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_RANDOM = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // x^8+x^6+x^5+x^4+1 -> register bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS         = 8'b1011_1000;
    localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// out is the value the register takes on the next advance.
module mole_lfsr
    import whack_pkg::*;
(
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    assign out    = lfsr_d;

    // A zero seed would lock the register at zero forever.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (adv) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/mole_slot_sequencer.sv
// Selects the lit mole slot (up/down/random/hold) on each tick,
// with direct load and registered hit detection.
module mole_slot_sequencer
    import whack_pkg::*;
#(
    parameter int         NUM_SLOTS = 4,
    parameter logic [7:0] LFSR_SEED = DEFAULT_LFSR_SEED,
    localparam int        CW        = $clog2(NUM_SLOTS)
) (
    input  logic                 clk_out,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [CW-1:0]        load_val,
    input  logic                 hit,
    output logic [CW-1:0]        slot,
    output logic [NUM_SLOTS-1:0] mole_onehot,
    output logic                 wrap,
    output logic                 hit_ok
);

    localparam logic [CW:0] LAST = (CW+1)'(NUM_SLOTS - 1);
    localparam logic [CW:0] NS   = (CW+1)'(NUM_SLOTS);

    logic [CW-1:0]        slot_q, slot_d;
    logic                 valid_q, valid_d;
    logic [NUM_SLOTS-1:0] onehot_q, onehot_d;
    logic                 wrap_q, wrap_d;
    logic                 hit_q, hit_d;

    logic        adv;
    logic [7:0]  lfsr_nx;
    logic [CW:0] cur_ext;
    logic [CW:0] up_ext;
    logic [CW:0] dn_ext;
    logic [CW:0] ld_ext;
    logic [CW:0] rnd_ext;

    mole_lfsr u_lfsr (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .adv     (adv),
        .seed    (LFSR_SEED),
        .out     (lfsr_nx)
    );

    assign cur_ext = {1'b0, slot_q};
    assign up_ext  = cur_ext + 1'b1;
    assign dn_ext  = cur_ext - 1'b1;
    assign ld_ext  = {1'b0, load_val};

    // Raw draw spans < 2*NUM_SLOTS, so one subtraction folds it in range.
    always_comb begin
        rnd_ext = {1'b0, lfsr_nx[CW-1:0]};
        if (rnd_ext >= NS) begin
            rnd_ext = rnd_ext - NS;
        end
        if (rnd_ext == cur_ext) begin
            rnd_ext = (rnd_ext == LAST) ? '0 : rnd_ext + 1'b1;
        end
    end

    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        hit_d   = 1'b0;
        adv     = 1'b0;
        if (load) begin
            slot_d  = (ld_ext > LAST) ? LAST[CW-1:0] : load_val;
            valid_d = 1'b1;
        end else if (tick) begin
            adv     = 1'b1;
            valid_d = 1'b1;
            unique case (mode_e'(mode))
                MODE_UP: begin
                    if (cur_ext == LAST) begin
                        slot_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        slot_d = up_ext[CW-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (cur_ext == '0) begin
                        slot_d = LAST[CW-1:0];
                        wrap_d = 1'b1;
                    end else begin
                        slot_d = dn_ext[CW-1:0];
                    end
                end
                MODE_RANDOM: slot_d = rnd_ext[CW-1:0];
                MODE_HOLD:   slot_d = slot_q;
            endcase
        end else if (hit && valid_q) begin
            valid_d = 1'b0;
            hit_d   = 1'b1;
        end
    end

    always_comb begin
        onehot_d = '0;
        if (valid_d) begin
            onehot_d = NUM_SLOTS'(1) << slot_d;
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            valid_q  <= 1'b1;
            onehot_q <= NUM_SLOTS'(1);
            wrap_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            wrap_q   <= wrap_d;
            hit_q    <= hit_d;
        end
    end

    assign slot        = slot_q;
    assign mole_onehot = onehot_q;
    assign wrap        = wrap_q;
    assign hit_ok      = hit_q;

endmodule

// File: tb/tb_mole_slot_sequencer.sv
// Self-checking bench: vector table, corner sequences and a
// randomized run against a behavioural model, for 4 and 5 slots.
module tb_mole_slot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       t4, l4, h4;
    logic [1:0] m4, lv4, slot4;
    logic [3:0] oh4;
    logic       w4, ho4;

    logic       t5, l5, h5;
    logic [1:0] m5;
    logic [2:0] lv5, slot5;
    logic [4:0] oh5;
    logic       w5, ho5;

    mole_slot_sequencer #(.NUM_SLOTS(4), .LFSR_SEED(8'hA5)) dut4 (
        .clk_out(clk), .rst_n(rst_n), .tick(t4), .mode(m4),
        .load(l4), .load_val(lv4), .hit(h4), .slot(slot4),
        .mole_onehot(oh4), .wrap(w4), .hit_ok(ho4));

    mole_slot_sequencer #(.NUM_SLOTS(5), .LFSR_SEED(8'hA5)) dut5 (
        .clk_out(clk), .rst_n(rst_n), .tick(t5), .mode(m5),
        .load(l5), .load_val(lv5), .hit(h5), .slot(slot5),
        .mole_onehot(oh5), .wrap(w5), .hit_ok(ho5));

    typedef struct {
        bit       tick;
        bit [1:0] mode;
        bit       load;
        int       lv;
        bit       hit;
    } in_t;

    typedef struct {
        int slot;
        int oh;
        bit wrap;
        bit hok;
    } exp_t;

    typedef struct {
        int slot;
        bit valid;
        int lfsr;
    } mst_t;

    typedef struct {
        bit       tick;
        bit [1:0] mode;
        bit       load;
        int       lv;
        bit       hit;
        int       slot;
        int       oh;
        bit       wrap;
        bit       hok;
    } vec_t;

    int   n_chk = 0;
    int   n_pass = 0;
    in_t  i4, i5;
    mst_t s4, s5;
    exp_t e4, e5;

    function automatic int lfsr_next(int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    function automatic void mreset(output mst_t s, output exp_t e);
        s.slot = 0; s.valid = 1; s.lfsr = 'hA5;
        e.slot = 0; e.oh = 1; e.wrap = 0; e.hok = 0;
    endfunction

    function automatic void mstep(input int n, input int cw,
                                  inout mst_t s, input in_t x,
                                  output exp_t e);
        int r;
        e.wrap = 0; e.hok = 0;
        if (x.load) begin
            s.slot  = (x.lv > n - 1) ? n - 1 : x.lv;
            s.valid = 1;
        end else if (x.tick) begin
            s.lfsr  = lfsr_next(s.lfsr);
            s.valid = 1;
            case (x.mode)
                2'd0: if (s.slot == n - 1) begin
                          s.slot = 0; e.wrap = 1;
                      end else s.slot++;
                2'd1: if (s.slot == 0) begin
                          s.slot = n - 1; e.wrap = 1;
                      end else s.slot--;
                2'd2: begin
                    r = s.lfsr % (1 << cw);
                    if (r >= n) r -= n;
                    if (r == s.slot) r = (r + 1) % n;
                    s.slot = r;
                end
                default: ;
            endcase
        end else if (x.hit && s.valid) begin
            s.valid = 0;
            e.hok   = 1;
        end
        e.slot = s.slot;
        e.oh   = s.valid ? (1 << s.slot) : 0;
    endfunction

    function automatic in_t idle(bit [1:0] m);
        in_t x;
        x.tick = 0; x.mode = m; x.load = 0; x.lv = 0; x.hit = 0;
        return x;
    endfunction

    function automatic in_t mk(bit t, bit [1:0] m, bit l, int v, bit h);
        in_t x;
        x.tick = t; x.mode = m; x.load = l; x.lv = v; x.hit = h;
        return x;
    endfunction

    function automatic exp_t ex(int s, int o, bit w, bit h);
        exp_t e;
        e.slot = s; e.oh = o; e.wrap = w; e.hok = h;
        return e;
    endfunction

    task automatic chk(string nm, int as, int ao, bit aw, bit ah,
                       exp_t e);
        n_chk++;
        if (as == e.slot && ao == e.oh && aw == e.wrap && ah == e.hok)
            n_pass++;
        else
            $display("FAIL %s: got slot=%0d oh=%0h wrap=%0d hit_ok=%0d, need slot=%0d oh=%0h wrap=%0d hit_ok=%0d",
                     nm, as, ao, aw, ah, e.slot, e.oh, e.wrap, e.hok);
    endtask

    task automatic chk4(string nm, exp_t e);
        chk(nm, int'(slot4), int'(oh4), w4, ho4, e);
    endtask

    task automatic chk5(string nm, exp_t e);
        chk(nm, int'(slot5), int'(oh5), w5, ho5, e);
    endtask

    task automatic cond(string nm, bit ok, int got, int need);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, need %0d", nm, got, need);
    endtask

    task automatic drive();
        t4 = i4.tick; m4 = i4.mode; l4 = i4.load;
        lv4 = 2'(i4.lv); h4 = i4.hit;
        t5 = i5.tick; m5 = i5.mode; l5 = i5.load;
        lv5 = 3'(i5.lv); h5 = i5.hit;
    endtask

    task automatic cyc();
        @(negedge clk);
        drive();
        @(posedge clk);
        #1;
        mstep(4, 2, s4, i4, e4);
        mstep(5, 3, s5, i5, e5);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        i4 = idle(2'd0);
        i5 = idle(2'd0);
        drive();
        mreset(s4, e4);
        mreset(s5, e5);
        #1;
        chk4("reset4", e4);
        chk5("reset5", e5);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[$];
    int   prev, visited, wrap_seen, held;

    initial begin
        rst_n = 1'b0;
        i4 = idle(2'd0);
        i5 = idle(2'd0);
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk4("reset_hold4", ex(0, 1, 0, 0));
        chk5("reset_hold5", ex(0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        mreset(s4, e4);
        mreset(s5, e5);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk4("idle_after_reset", ex(0, 1, 0, 0));
        end

        tbl.push_back('{1, 0, 0, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 2, 4, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 3, 8, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 2, 0, 2, 4, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 2, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 3, 8, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 3, 8, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 1, 2, 0, 0});
        tbl.push_back('{1, 3, 0, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{0, 3, 0, 0, 1, 1, 0, 0, 1});
        tbl.push_back('{1, 3, 0, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{0, 0, 1, 3, 1, 3, 8, 0, 0});
        foreach (tbl[k]) begin
            i4 = mk(tbl[k].tick, tbl[k].mode, tbl[k].load,
                    tbl[k].lv, tbl[k].hit);
            cyc();
            chk4($sformatf("vec%0d", k),
                 ex(tbl[k].slot, tbl[k].oh, tbl[k].wrap, tbl[k].hok));
        end

        do_reset();
        i5 = mk(1, 2'd1, 0, 0, 0);
        cyc(); chk5("down5_wrap", ex(4, 16, 1, 0));
        cyc(); chk5("down5_step", ex(3, 8, 0, 0));
        i5 = mk(0, 2'd0, 1, 6, 0);
        cyc(); chk5("load5_clamp6", ex(4, 16, 0, 0));
        i5 = mk(0, 2'd0, 1, 7, 0);
        cyc(); chk5("load5_clamp7", ex(4, 16, 0, 0));
        i5 = mk(0, 2'd0, 1, 1, 0);
        cyc(); chk5("load5_1", ex(1, 2, 0, 0));
        i5 = mk(1, 2'd0, 1, 0, 0);
        cyc(); chk5("load_over_tick", ex(0, 1, 0, 0));
        i5 = idle(2'd0);

        do_reset();
        visited = 0; wrap_seen = 0; prev = 0;
        i4 = mk(1, 2'd2, 0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            cyc();
            chk4("random_model", e4);
            cond("random_no_repeat", int'(slot4) != prev,
                 int'(slot4), prev);
            prev = int'(slot4);
            visited |= 1 << slot4;
            if (w4) wrap_seen++;
        end
        cond("random_all_visited", visited == 15, visited, 15);
        cond("random_no_wrap", wrap_seen == 0, wrap_seen, 0);
        held = int'(slot4);
        i4 = mk(1, 2'd3, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            cond("hold_const", int'(slot4) == held, int'(slot4), held);
        end
        i4 = mk(1, 2'd2, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk4("random_after_hold", e4);
        end

        for (int k = 0; k < 400; k++) begin
            i4 = mk($urandom_range(2) == 0, 2'($urandom),
                    $urandom_range(7) == 0, $urandom_range(3),
                    $urandom_range(2) == 0);
            i5 = mk($urandom_range(2) == 0, 2'($urandom),
                    $urandom_range(7) == 0, $urandom_range(7),
                    $urandom_range(2) == 0);
            cyc();
            chk4("rand4", e4);
            chk5("rand5", e5);
            if (k == 200) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
